// File: rtl/mult_share_pkg.sv
// Shared types and the round-robin pick helper for the multiplier-sharing arbiter.
// Type widths follow the DEF_* defaults below; instantiate the top with matching parameters.
package mult_share_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_MUL_LATENCY = 7;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int REQ_ID_W        = (DEF_N_REQ > 1) ? $clog2(DEF_N_REQ) : 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    req_id_t                       id;
    logic [2*DEF_DATA_WIDTH-1:0]   data;
  } rsp_entry_t;

  // Returns {found, index}: first asserted valid bit at or after ptr, wrapping.
  function automatic logic [REQ_ID_W:0] rr_pick(input logic [DEF_N_REQ-1:0] valid,
                                                input req_id_t               ptr);
    logic [REQ_ID_W:0] res;
    int                idx;
    res = '0;
    for (int k = DEF_N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % DEF_N_REQ;
      if (valid[idx]) res = {1'b1, req_id_t'(idx)};
    end
    return res;
  endfunction

endpackage

// File: rtl/inferred_multiplier_pl.sv
// Plain pipelined multiplier: product appears PIPELINE_STAGES cycles after the operands.
// No stall and no reset; the arbiter's tag pipe decides which outputs are meaningful.
module inferred_multiplier_pl #(
  parameter int DATA_WIDTH      = 16,
  parameter int PIPELINE_STAGES = 7
) (
  input  logic                    clk_i,
  input  logic [DATA_WIDTH-1:0]   in1_i,
  input  logic [DATA_WIDTH-1:0]   in2_i,
  output logic [2*DATA_WIDTH-1:0] out_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] stage_q [PIPELINE_STAGES];

  always_ff @(posedge clk_i) begin
    stage_q[0] <= PW'(in1_i) * PW'(in2_i);
    for (int i = 1; i < PIPELINE_STAGES; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[PIPELINE_STAGES-1];

endmodule

// File: rtl/mult_share_rsp_fifo.sv
// Result FIFO of {id, product} entries with a registered head and an occupancy count.
// The arbiter's credit check guarantees a push never lands on a full FIFO without a pop.
module mult_share_rsp_fifo
  import mult_share_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  rsp_entry_t    push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output rsp_entry_t    head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) wr_q <= bump(wr_q);
      if (do_pop) rd_q <= bump(rd_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one fixed-latency multiplier among N_REQ requesters, results in issue order.
// Optional MULT_SHARE_ARB_STATS_EN adds saturating per-requester grant counters on grant_count_o.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_a_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_b_i,
  output logic [DATA_WIDTH-1:0]               mul_in1_o,
  output logic [DATA_WIDTH-1:0]               mul_in2_o,
  input  logic [2*DATA_WIDTH-1:0]             mul_out_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output req_id_t                             rsp_id_o,
  output logic [2*DATA_WIDTH-1:0]             rsp_data_o
`ifdef MULT_SHARE_ARB_STATS_EN
  ,output logic [N_REQ-1:0][31:0]             grant_count_o
`endif
);

  localparam int            OW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  logic [REQ_ID_W:0]      pick;
  logic                   found, pop, credit_ok, issue, push;
  req_id_t                win, ptr_q, ptr_d;
  logic [OW-1:0]          inflight_q, inflight_d, fifo_cnt, outstanding;
  logic [MUL_LATENCY-1:0] tag_vld_q;
  req_id_t                tag_id_q [MUL_LATENCY];
  rsp_entry_t             push_entry, head;

  assign pick  = rr_pick(req_valid_i, ptr_q);
  assign found = pick[REQ_ID_W];
  assign win   = pick[REQ_ID_W-1:0];

  // Outstanding = ops still in the multiplier plus results parked in the FIFO.
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign outstanding = inflight_q + fifo_cnt;
  assign credit_ok   = (outstanding < DEPTH_C) || ((outstanding == DEPTH_C) && pop);
  assign issue       = found & credit_ok & ~reset_i;

  always_comb begin
    req_ready_o = '0;
    if (issue) req_ready_o[win] = 1'b1;
  end

  assign mul_in1_o = issue ? req_a_i[win] : '0;
  assign mul_in2_o = issue ? req_b_i[win] : '0;

  assign ptr_d = !issue ? ptr_q :
                 (win == req_id_t'(N_REQ - 1)) ? '0 : win + 1'b1;

  assign push       = tag_vld_q[MUL_LATENCY-1];
  assign push_entry = '{id: tag_id_q[MUL_LATENCY-1], data: mul_out_i};

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      tag_vld_q  <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      inflight_q   <= inflight_d;
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= win;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  mult_share_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (OW)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .valid_o     (rsp_valid_o),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  assign rsp_id_o   = head.id;
  assign rsp_data_o = head.data;

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] grant_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_cnt_q <= '0;
    end else if (issue && (grant_cnt_q[win] != '1)) begin
      grant_cnt_q[win] <= grant_cnt_q[win] + 32'd1;
    end
  end

  assign grant_count_o = grant_cnt_q;
`endif

endmodule
